// File: rtl/hazard_unit_mc_pkg.sv
// Shared types and constants for the pipeline hazard unit.
package hazard_pkg;

  typedef enum logic [1:0] {
    FWD_RF = 2'b00,
    FWD_W  = 2'b01,
    FWD_M  = 2'b10
  } fwd_sel_t;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    BUSY = 2'b01,
    DONE = 2'b10
  } md_state_t;

  localparam logic [1:0] PCSRC_SEQ = 2'b00;

endpackage

// File: rtl/hazard_unit_mc_if.sv
// Pipeline-to-hazard-unit bundle: stage register addresses and controls in,
// stall/flush/forward controls out.
interface hazard_unit_mc_if #(
  parameter int REG_AW = 5,
  parameter int CNT_W  = 32
);
  logic [REG_AW-1:0] Rs1D_i, Rs2D_i;
  logic [REG_AW-1:0] Rs1E_i, Rs2E_i, RdE_i;
  logic [1:0]        PCSrcE_i;
  logic              ResultSrcE_i;
  logic              MdStartE_i;
  logic [REG_AW-1:0] RdM_i;
  logic              RegWriteM_i;
  logic              MemReadyM_i;
  logic [REG_AW-1:0] RdW_i;
  logic              RegWriteW_i;
  logic              StallF_o, StallD_o, StallE_o, StallM_o;
  logic              FlushD_o, FlushE_o, FlushM_o, FlushW_o;
  logic [1:0]        ForwardAE_o, ForwardBE_o;
  logic              MdBusy_o;
  logic [CNT_W-1:0]  StallCnt_o;

  modport master (
    output Rs1D_i, Rs2D_i, Rs1E_i, Rs2E_i, RdE_i, PCSrcE_i, ResultSrcE_i,
           MdStartE_i, RdM_i, RegWriteM_i, MemReadyM_i, RdW_i, RegWriteW_i,
    input  StallF_o, StallD_o, StallE_o, StallM_o,
           FlushD_o, FlushE_o, FlushM_o, FlushW_o,
           ForwardAE_o, ForwardBE_o, MdBusy_o, StallCnt_o
  );

  modport slave (
    input  Rs1D_i, Rs2D_i, Rs1E_i, Rs2E_i, RdE_i, PCSrcE_i, ResultSrcE_i,
           MdStartE_i, RdM_i, RegWriteM_i, MemReadyM_i, RdW_i, RegWriteW_i,
    output StallF_o, StallD_o, StallE_o, StallM_o,
           FlushD_o, FlushE_o, FlushM_o, FlushW_o,
           ForwardAE_o, ForwardBE_o, MdBusy_o, StallCnt_o
  );
endinterface

// File: rtl/hazard_unit_mc_fwd_sel.sv
// Operand bypass select for one E-stage source register; M beats W, x0 never bypassed.
module fwd_sel
  import hazard_pkg::*;
#(
  parameter int REG_AW = 5
) (
  input  logic [REG_AW-1:0] rs_e,
  input  logic [REG_AW-1:0] rd_m,
  input  logic              reg_write_m,
  input  logic [REG_AW-1:0] rd_w,
  input  logic              reg_write_w,
  output fwd_sel_t          sel
);

  // Priority select: most recent producer wins.
  always_comb begin
    sel = FWD_RF;
    if (reg_write_m && (rd_m != '0) && (rd_m == rs_e)) begin
      sel = FWD_M;
    end else if (reg_write_w && (rd_w != '0) && (rd_w == rs_e)) begin
      sel = FWD_W;
    end
  end

endmodule

// File: rtl/hazard_unit_mc.sv
// Hazard unit for the 5-stage RV32I pipeline: load-use, redirect, mul/div
// occupancy of E and data-memory wait states, plus a stall-cycle counter.
//
// state | meaning
// IDLE  | no mul/div in progress; a start in E stalls and (if memory ready) launches
// BUSY  | mul/div holding E; countdown of remaining stall cycles
// DONE  | op left E last edge; start ignored so the same op cannot re-trigger
module hazard_unit_mc
  import hazard_pkg::*;
#(
  parameter int REG_AW = 5,
  parameter int MD_LAT = 4,
  parameter int CNT_W  = 32
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  hazard_unit_mc_if.slave  bus
);

  localparam int CW = (MD_LAT > 2) ? $clog2(MD_LAT) : 1;
  localparam logic [CW-1:0] CNT_LOAD = CW'(MD_LAT - 2);

  md_state_t        state, state_nxt;
  logic [CW-1:0]    md_cnt, md_cnt_nxt;
  logic [CNT_W-1:0] stall_cnt;
  logic             mem_stall, md_stall, stall_e, stall_f;
  logic             redirect, lw_stall;
  fwd_sel_t         fwd_a, fwd_b;

  fwd_sel #(.REG_AW(REG_AW)) u_fwd_a (
    .rs_e        (bus.Rs1E_i),
    .rd_m        (bus.RdM_i),
    .reg_write_m (bus.RegWriteM_i),
    .rd_w        (bus.RdW_i),
    .reg_write_w (bus.RegWriteW_i),
    .sel         (fwd_a)
  );

  fwd_sel #(.REG_AW(REG_AW)) u_fwd_b (
    .rs_e        (bus.Rs2E_i),
    .rd_m        (bus.RdM_i),
    .reg_write_m (bus.RegWriteM_i),
    .rd_w        (bus.RdW_i),
    .reg_write_w (bus.RegWriteW_i),
    .sel         (fwd_b)
  );

  // MD FSM state and countdown registers.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state  <= IDLE;
      md_cnt <= '0;
    end else begin
      state  <= state_nxt;
      md_cnt <= md_cnt_nxt;
    end
  end

  // MD next state; the countdown freezes while memory holds the whole pipe.
  always_comb begin
    state_nxt  = state;
    md_cnt_nxt = md_cnt;
    md_stall   = 1'b0;
    mem_stall  = !bus.MemReadyM_i;
    case (state)
      IDLE: begin
        md_stall = bus.MdStartE_i;
        if (bus.MdStartE_i && !mem_stall) begin
          state_nxt  = BUSY;
          md_cnt_nxt = CNT_LOAD;
        end
      end
      BUSY: begin
        if (md_cnt != '0) begin
          md_stall = 1'b1;
          if (!mem_stall) md_cnt_nxt = md_cnt - CW'(1);
        end else if (!mem_stall) begin
          state_nxt = DONE;
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Stall/flush combination; memory wait outranks everything, reset forces all low.
  always_comb begin
    stall_e  = mem_stall || md_stall;
    redirect = (bus.PCSrcE_i != PCSRC_SEQ) && !stall_e;
    lw_stall = bus.ResultSrcE_i && (bus.RdE_i != '0) &&
               ((bus.RdE_i == bus.Rs1D_i) || (bus.RdE_i == bus.Rs2D_i)) &&
               !redirect && !stall_e;
    stall_f  = stall_e || lw_stall;

    bus.StallF_o = rst_n_i && stall_f;
    bus.StallD_o = rst_n_i && stall_f;
    bus.StallE_o = rst_n_i && stall_e;
    bus.StallM_o = rst_n_i && mem_stall;
    bus.FlushD_o = rst_n_i && redirect;
    bus.FlushE_o = rst_n_i && (redirect || lw_stall);
    bus.FlushM_o = rst_n_i && md_stall && !mem_stall;
    bus.FlushW_o = rst_n_i && mem_stall;
  end

  // Saturating count of front-end stall cycles.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      stall_cnt <= '0;
    end else if (stall_f && (stall_cnt != '1)) begin
      stall_cnt <= stall_cnt + CNT_W'(1);
    end
  end

  assign bus.ForwardAE_o = fwd_a;
  assign bus.ForwardBE_o = fwd_b;
  assign bus.MdBusy_o    = (state != IDLE);
  assign bus.StallCnt_o  = stall_cnt;

endmodule

// File: tb/tb_hazard_unit_mc.sv
// Scoreboard bench: every applied cycle pushes the reference-model response,
// a negedge monitor pops and compares against the DUT outputs.
module tb_hazard_unit_mc;
  import hazard_pkg::*;

  localparam int REG_AW = 5;
  localparam int MD_LAT = 4;
  localparam int CNT_W  = 4;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic clk_i = 1'b0;
  logic rst_n_i = 1'b0;
  always #5 clk_i = ~clk_i;

  hazard_unit_mc_if #(.REG_AW(REG_AW), .CNT_W(CNT_W)) bus ();

  hazard_unit_mc #(.REG_AW(REG_AW), .MD_LAT(MD_LAT), .CNT_W(CNT_W)) dut (
    .clk_i   (clk_i),
    .rst_n_i (rst_n_i),
    .bus     (bus.slave)
  );

  typedef struct packed {
    logic [3:0]       stall;   // F D E M
    logic [3:0]       flush;   // D E M W
    logic [1:0]       fa;
    logic [1:0]       fb;
    logic             busy;
    logic [CNT_W-1:0] cnt;
  } exp_t;

  typedef struct {
    bit         rst_n;
    logic [4:0] rs1d, rs2d, rs1e, rs2e, rde, rdm, rdw;
    logic [1:0] pcsrc;
    bit         ld, md, rwm, rww, memrdy;
  } stim_t;

  exp_t exp_q[$];
  int   n_vec = 0;
  int   n_bad = 0;

  // Reference model: mul/div tracked as "productive cycles spent in E".
  bit m_in_op = 0;
  int m_served = 0;
  bit m_cool = 0;
  int m_cnt = 0;

  function automatic logic [1:0] ref_fwd(input logic [4:0] rs, input logic [4:0] rdm,
                                         input bit rwm, input logic [4:0] rdw, input bit rww);
    if (rwm && rdm != 0 && rdm == rs) return 2'b10;
    if (rww && rdw != 0 && rdw == rs) return 2'b01;
    return 2'b00;
  endfunction

  function automatic stim_t idle_stim();
    stim_t s;
    s.rst_n = 1; s.rs1d = 0; s.rs2d = 0; s.rs1e = 0; s.rs2e = 0; s.rde = 0;
    s.rdm = 0; s.rdw = 0; s.pcsrc = 0; s.ld = 0; s.md = 0; s.rwm = 0; s.rww = 0;
    s.memrdy = 1;
    return s;
  endfunction

  task automatic step(input stim_t s);
    exp_t e;
    bit mem, mdst, se, redir, lw, sf;
    @(posedge clk_i);
    #1;
    bus.Rs1D_i = s.rs1d; bus.Rs2D_i = s.rs2d; bus.Rs1E_i = s.rs1e; bus.Rs2E_i = s.rs2e;
    bus.RdE_i = s.rde; bus.PCSrcE_i = s.pcsrc; bus.ResultSrcE_i = s.ld;
    bus.MdStartE_i = s.md; bus.RdM_i = s.rdm; bus.RegWriteM_i = s.rwm;
    bus.MemReadyM_i = s.memrdy; bus.RdW_i = s.rdw; bus.RegWriteW_i = s.rww;
    rst_n_i = s.rst_n;
    e.fa = ref_fwd(s.rs1e, s.rdm, s.rwm, s.rdw, s.rww);
    e.fb = ref_fwd(s.rs2e, s.rdm, s.rwm, s.rdw, s.rww);
    if (!s.rst_n) begin
      m_in_op = 0; m_served = 0; m_cool = 0; m_cnt = 0;
      e.stall = 0; e.flush = 0; e.busy = 0; e.cnt = 0;
      exp_q.push_back(e);
      return;
    end
    mem   = !s.memrdy;
    mdst  = m_in_op ? (m_served < MD_LAT - 1) : (!m_cool && s.md);
    se    = mem || mdst;
    redir = (s.pcsrc != 0) && !se;
    lw    = s.ld && s.rde != 0 && (s.rde == s.rs1d || s.rde == s.rs2d) && !redir && !se;
    sf    = se || lw;
    e.stall = {sf, sf, se, mem};
    e.flush = {redir, redir || lw, mdst && !mem, mem};
    e.busy  = m_in_op || m_cool;
    e.cnt   = CNT_W'(m_cnt);
    exp_q.push_back(e);
    if (sf && m_cnt < CNT_MAX) m_cnt++;
    if (m_cool) begin
      m_cool = 0;
    end else if (m_in_op) begin
      if (!mem) begin
        m_served++;
        if (m_served == MD_LAT) begin
          m_in_op = 0;
          m_cool = 1;
        end
      end
    end else if (s.md && !mem) begin
      m_in_op = 1;
      m_served = 1;
    end
  endtask

  // Monitor: one response per cycle, compared mid-cycle.
  always @(negedge clk_i) begin
    exp_t e, g;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      g.stall = {bus.StallF_o, bus.StallD_o, bus.StallE_o, bus.StallM_o};
      g.flush = {bus.FlushD_o, bus.FlushE_o, bus.FlushM_o, bus.FlushW_o};
      g.fa = bus.ForwardAE_o;
      g.fb = bus.ForwardBE_o;
      g.busy = bus.MdBusy_o;
      g.cnt = bus.StallCnt_o;
      n_vec++;
      if (g !== e) begin
        n_bad++;
        $display("FAIL outputs vec %0d: got stall=%b flush=%b fa=%b fb=%b busy=%b cnt=%0d, want stall=%b flush=%b fa=%b fb=%b busy=%b cnt=%0d",
                 n_vec, g.stall, g.flush, g.fa, g.fb, g.busy, g.cnt,
                 e.stall, e.flush, e.fa, e.fb, e.busy, e.cnt);
      end
    end
  end

  initial begin
    stim_t s;
    s = idle_stim();
    s.rst_n = 0;
    repeat (2) step(s);

    // forwarding priority
    s = idle_stim(); s.rwm = 1; s.rdm = 5; s.rww = 1; s.rdw = 5; s.rs1e = 5;
    step(s);
    s.rdm = 0; step(s);
    s.rdw = 0; s.rs2e = 0; step(s);

    // load-use, then x0 destination
    s = idle_stim(); s.ld = 1; s.rde = 7; s.rs2d = 7; step(s);
    step(idle_stim());
    s.rde = 0; s.rs2d = 0; step(s);

    // mul/div held in E, start still asserted through DONE
    s = idle_stim(); s.md = 1;
    repeat (5) step(s);
    repeat (2) step(idle_stim());

    // memory wait mid-BUSY
    s = idle_stim(); s.md = 1;
    repeat (2) step(s);
    s.memrdy = 0; repeat (2) step(s);
    s.memrdy = 1; repeat (2) step(s);
    repeat (2) step(idle_stim());

    // redirect, then redirect deferred by memory wait
    s = idle_stim(); s.pcsrc = 2'b01; step(s);
    s.memrdy = 0; repeat (2) step(s);
    s.memrdy = 1; step(s);
    step(idle_stim());

    // async reset mid-BUSY
    s = idle_stim(); s.md = 1; repeat (2) step(s);
    s.rst_n = 0; repeat (2) step(s);
    repeat (2) step(idle_stim());

    // counter saturation
    s = idle_stim(); s.memrdy = 0; repeat (20) step(s);
    step(idle_stim());

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      s.rst_n  = ($urandom_range(0, 60) != 0);
      s.rs1d   = 5'($urandom_range(0, 3));
      s.rs2d   = 5'($urandom_range(0, 3));
      s.rs1e   = 5'($urandom_range(0, 3));
      s.rs2e   = 5'($urandom_range(0, 3));
      s.rde    = 5'($urandom_range(0, 3));
      s.rdm    = 5'($urandom_range(0, 3));
      s.rdw    = 5'($urandom_range(0, 3));
      s.pcsrc  = ($urandom_range(0, 4) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
      s.ld     = ($urandom_range(0, 2) == 0);
      s.md     = ($urandom_range(0, 5) == 0);
      s.rwm    = 1'($urandom_range(0, 1));
      s.rww    = 1'($urandom_range(0, 1));
      s.memrdy = ($urandom_range(0, 4) != 0);
      step(s);
    end

    for (int k = 0; k < 10 && exp_q.size() != 0; k++) @(posedge clk_i);
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL drain: %0d responses left, want 0", exp_q.size());
    end
    if (n_vec == 0) begin
      n_bad++;
      $display("FAIL activity: got 0 vectors compared, want >0");
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
